mux_n_skid: RTL

Parametrised N-input, WIDTH-bit multiplexer with a registered, ready/valid-handshaked output stage. It is the successor to the fixed 4:1 32-bit datapath mux.
- Adds a 2-entry skid buffer for full throughput under backpressure.
- Adds a select-lock mode so a multi-beat transfer keeps its source.
- Adds out-of-range select detection.
- Sits between the datapath sources (PC, ALU, memory data, immediates) and any consumer that may stall.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux_n_comb.sv | 31 +++
 rtl/mux_n_skid.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and limits for the N-input skid-buffered output mux.
`ifndef MUX_PKG_SV
`define MUX_PKG_SV

// The payload depends on module parameters, so the struct body is expanded inside each user.
`define MUX_PAYLOAD_T(W, S) struct packed { logic [(W)-1:0] data; logic [(S)-1:0] sel; logic err; }

package mux_pkg;

    typedef enum logic [1:0] {
        MUX_EMPTY = 2'd0,
        MUX_ONE   = 2'd1,
        MUX_TWO   = 2'd2
    } mux_state_t;

    localparam int MUX_MAX_IN = 16;

endpackage

`endif

// File: rtl/mux_n_comb.sv
// Purely combinational N_IN:1 selector; a select beyond the last input yields zero data and err=1.
module mux_n_comb
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 4,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]      data,
    output logic                  err
);

    if (N_IN < 2 || N_IN > MUX_MAX_IN) begin : g_bad_n_in
        $error("mux_n_comb: N_IN must lie in 2..%0d", MUX_MAX_IN);
    end

    // err stays set unless some input index matches, which covers the unused codes when N_IN is not a power of 2.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_skid.sv
// N-input mux with select lock and a two-entry registered output stage (main + skid) on a ready/valid link.
module mux_n_skid
    import mux_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int N_IN        = 4,
    parameter  int DEFAULT_SEL = 0,
    localparam int SEL_W       = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_lock,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef `MUX_PAYLOAD_T(WIDTH, SEL_W) payload_t;

    mux_state_t       state_q, state_d;
    payload_t         main_q, main_d;
    payload_t         skid_q, skid_d;
    payload_t         payload;
    logic             in_ready_q, in_ready_d;
    logic             sel_lock_q, sel_lock_d;
    logic [SEL_W-1:0] locked_sel_q, locked_sel_d;
    logic [SEL_W-1:0] eff_sel;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             pop;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // The lock edge captures sel but still routes sel itself on that cycle.
    always_comb begin
        sel_lock_d   = sel_lock;
        locked_sel_d = locked_sel_q;
        eff_sel      = sel;
        if (sel_lock && !sel_lock_q) begin
            locked_sel_d = sel;
        end
        if (sel_lock && sel_lock_q) begin
            eff_sel = locked_sel_q;
        end
    end

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_comb (
        .sel     (eff_sel),
        .in_data (in_data),
        .data    (sel_data),
        .err     (sel_err)
    );

    always_comb begin
        payload      = '0;
        payload.data = sel_data;
        payload.sel  = eff_sel;
        payload.err  = sel_err;
    end

    assign accept = in_valid && in_ready_q;
    assign pop    = (state_q != MUX_EMPTY) && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MUX_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUX_EMPTY: begin
                if (accept) begin
                    state_d = MUX_ONE;
                end
            end
            MUX_ONE: begin
                if (accept && !pop) begin
                    state_d = MUX_TWO;
                end else if (pop && !accept) begin
                    state_d = MUX_EMPTY;
                end
            end
            MUX_TWO: begin
                if (pop) begin
                    state_d = MUX_ONE;
                end
            end
            default: state_d = MUX_EMPTY;
        endcase
    end

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            MUX_EMPTY: load_main_in = accept;
            MUX_ONE: begin
                load_main_in = accept && pop;
                load_skid    = accept && !pop;
            end
            MUX_TWO:   load_main_skid = pop;
            default: ;
        endcase
        in_ready_d = (state_d != MUX_TWO);
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (load_main_in) begin
            main_d = payload;
        end else if (load_main_skid) begin
            main_d = skid_q;
        end
        if (load_skid) begin
            skid_d = payload;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            in_ready_q   <= 1'b1;
            sel_lock_q   <= 1'b0;
            locked_sel_q <= SEL_W'(DEFAULT_SEL);
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            in_ready_q   <= in_ready_d;
            sel_lock_q   <= sel_lock_d;
            locked_sel_q <= locked_sel_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != MUX_EMPTY);
    assign out_data  = main_q.data;
    assign out_sel   = main_q.sel;
    assign out_err   = main_q.err;

endmodule
